// File: rtl/io_pwm_gen.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel
// shadowed duty compare, with duty values reloaded only at period wrap.

module io_pwm_ch #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              load,
  input  logic [DUTY_W-1:0] cfg,
  input  logic [DUTY_W-1:0] per_cnt,
  input  logic              pol,
  output logic [DUTY_W-1:0] shadow,
  output logic              out
);
  // While disabled the shadow tracks cfg so a restart uses the freshest value
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadow <= '0;
      out    <= 1'b0;
    end else begin
      if (!en || load) shadow <= cfg;
      out <= en ? ((per_cnt < shadow) ^ pol) : 1'b0;
    end
  end
endmodule

module io_pwm_gen #(
  parameter int NUM_CH       = 4,
  parameter int DUTY_W       = 8,
  parameter int PRESCALE_DIV = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     en,
  input  logic [31:0]              pwm_cfg,
  input  logic [NUM_CH-1:0]        pol,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start,
  output logic [NUM_CH*DUTY_W-1:0] duty_active
);
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [PW-1:0]                   pre_cnt;
  logic [DUTY_W-1:0]               per_cnt;
  logic                            tick, wrap;
  logic [NUM_CH-1:0][DUTY_W-1:0]   cfg_f;
  logic [NUM_CH-1:0][DUTY_W-1:0]   shadow;

  assign tick  = (pre_cnt == PW'(PRESCALE_DIV - 1));
  assign wrap  = tick && (per_cnt == '1);
  assign cfg_f = pwm_cfg[NUM_CH*DUTY_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pre_cnt      <= '0;
      per_cnt      <= '0;
      period_start <= 1'b0;
    end else if (!en) begin
      pre_cnt      <= '0;
      per_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        per_cnt <= per_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      period_start <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_pwm_ch #(.DUTY_W(DUTY_W)) u_ch (
      .clk    (clk),
      .nrst   (nrst),
      .en     (en),
      .load   (wrap),
      .cfg    (cfg_f[i]),
      .per_cnt(per_cnt),
      .pol    (pol[i]),
      .shadow (shadow[i]),
      .out    (pwm_out[i])
    );
  end

  assign duty_active = shadow;
endmodule

// File: tb/tb_io_pwm_gen.sv
// Bench for io_pwm_gen: a DIV=1 and a DIV=16 instance share stimulus; expected
// values are queued when stimulus is applied and popped when outputs are measured.
module tb_io_pwm_gen;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] cfg = '0;
  logic [3:0]  pol = '0;
  logic [3:0]  out1, out16;
  logic        ps1, ps16;
  logic [31:0] da1, da16;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  io_pwm_gen #(.NUM_CH(4), .DUTY_W(8), .PRESCALE_DIV(1)) u1 (
    .clk(clk), .nrst(nrst), .en(en), .pwm_cfg(cfg), .pol(pol),
    .pwm_out(out1), .period_start(ps1), .duty_active(da1));

  io_pwm_gen #(.NUM_CH(4), .DUTY_W(8), .PRESCALE_DIV(16)) u16 (
    .clk(clk), .nrst(nrst), .en(en), .pwm_cfg(cfg), .pol(pol),
    .pwm_out(out16), .period_start(ps16), .duty_active(da16));

  task automatic test_reset();
    int e;
    nrst = 1'b0; en = 1'b0; cfg = '0; pol = 4'hF;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    en = 1'b1;
    exp_q.push_back(4'hF); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    repeat (256) @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1) !== e) begin n_fail++; $display("FAIL reset_pre_out got %h want %h", out1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ps1) !== e) begin n_fail++; $display("FAIL reset_pre_ps got %b want %0d", ps1, e); end
    #1 nrst = 1'b0;
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1) !== e) begin n_fail++; $display("FAIL reset_async_out got %h want %h", out1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ps1) !== e) begin n_fail++; $display("FAIL reset_async_ps got %b want %0d", ps1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(out16) !== e) begin n_fail++; $display("FAIL reset_async_out16 got %h want %h", out16, e); end
    en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1) !== e) begin n_fail++; $display("FAIL reset_release_out got %h want %h", out1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(out16) !== e) begin n_fail++; $display("FAIL reset_release_out16 got %h want %h", out16, e); end
  endtask

  task automatic test_duty_div1();
    int hi[4];
    int pc, first, e;
    hi = '{0, 0, 0, 0}; pc = 0; first = 0;
    en = 1'b0; pol = '0; cfg = 32'h00FF8000;
    repeat (2) @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(128); exp_q.push_back(255); exp_q.push_back(0);
    exp_q.push_back(3); exp_q.push_back(256); exp_q.push_back(32'h00FF8000);
    en = 1'b1;
    for (int k = 1; k <= 768; k++) begin
      @(negedge clk);
      if (k <= 256) for (int c = 0; c < 4; c++) hi[c] += int'(out1[c]);
      if (ps1 === 1'b1) begin pc++; if (first == 0) first = k; end
    end
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front(); n_checks++;
      if (hi[c] !== e) begin n_fail++; $display("FAIL duty_high_ch%0d got %0d want %0d", c, hi[c], e); end
    end
    e = exp_q.pop_front(); n_checks++;
    if (pc !== e) begin n_fail++; $display("FAIL duty_ps_count got %0d want %0d", pc, e); end
    e = exp_q.pop_front(); n_checks++;
    if (first !== e) begin n_fail++; $display("FAIL duty_ps_first got %0d want %0d", first, e); end
    e = exp_q.pop_front(); n_checks++;
    if (da1 !== e) begin n_fail++; $display("FAIL duty_active got %h want %h", da1, e); end
  endtask

  task automatic test_prescale();
    int hi, pc, first, e;
    hi = 0; pc = 0; first = 0;
    en = 1'b0; pol = '0; cfg = 32'h00000040;
    repeat (2) @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(1024); exp_q.push_back(1); exp_q.push_back(4096);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out16[0]) !== e) begin n_fail++; $display("FAIL pre_idle got %b want %0d", out16[0], e); end
    en = 1'b1;
    for (int k = 1; k <= 4096; k++) begin
      @(negedge clk);
      if (k == 1) begin
        e = exp_q.pop_front(); n_checks++;
        if (32'(out16[0]) !== e) begin n_fail++; $display("FAIL pre_first_rise got %b want %0d", out16[0], e); end
      end
      hi += int'(out16[0]);
      if (ps16 === 1'b1) begin pc++; if (first == 0) first = k; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (hi !== e) begin n_fail++; $display("FAIL pre_high got %0d want %0d", hi, e); end
    e = exp_q.pop_front(); n_checks++;
    if (pc !== e) begin n_fail++; $display("FAIL pre_ps_count got %0d want %0d", pc, e); end
    e = exp_q.pop_front(); n_checks++;
    if (first !== e) begin n_fail++; $display("FAIL pre_ps_first got %0d want %0d", first, e); end
  endtask

  task automatic test_shadow();
    int hi[3];
    int e;
    hi = '{0, 0, 0};
    en = 1'b0; pol = '0; cfg = 32'h00000010;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h10); exp_q.push_back(8'hF0); exp_q.push_back(8'h20);
    exp_q.push_back(16); exp_q.push_back(240); exp_q.push_back(32);
    en = 1'b1;
    for (int k = 1; k <= 768; k++) begin
      @(negedge clk);
      hi[(k - 1) / 256] += int'(out1[0]);
      if (k == 128) cfg = 32'h00000055;
      if (k == 200) cfg = 32'h000000F0;
      if (k == 511) cfg = 32'h00000020;
      if (k == 255 || k == 256 || k == 512) begin
        e = exp_q.pop_front(); n_checks++;
        if (32'(da1[7:0]) !== e) begin n_fail++; $display("FAIL shadow_active@%0d got %h want %h", k, da1[7:0], e); end
      end
    end
    for (int p = 0; p < 3; p++) begin
      e = exp_q.pop_front(); n_checks++;
      if (hi[p] !== e) begin n_fail++; $display("FAIL shadow_high_p%0d got %0d want %0d", p, hi[p], e); end
    end
  endtask

  task automatic test_disable();
    int hi, pc_early, e;
    hi = 0; pc_early = 0;
    en = 1'b0; pol = '0; cfg = 32'h000000FF;
    repeat (2) @(negedge clk);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(8'h07);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(1);
    en = 1'b1;
    repeat (48) @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL dis_running got %b want %0d", out1[0], e); end
    en = 1'b0; cfg = 32'h00000007;
    @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1) !== e) begin n_fail++; $display("FAIL dis_out got %h want %h", out1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ps1) !== e) begin n_fail++; $display("FAIL dis_ps got %b want %0d", ps1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(da1[7:0]) !== e) begin n_fail++; $display("FAIL dis_active got %h want %h", da1[7:0], e); end
    en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1 || k == 8) begin
        e = exp_q.pop_front(); n_checks++;
        if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL restart_out@%0d got %b want %0d", k, out1[0], e); end
      end
      hi += int'(out1[0]);
      if (k < 256 && ps1 === 1'b1) pc_early++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (hi !== e) begin n_fail++; $display("FAIL restart_high got %0d want %0d", hi, e); end
    e = exp_q.pop_front(); n_checks++;
    if (pc_early !== e) begin n_fail++; $display("FAIL restart_no_ps got %0d want %0d", pc_early, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ps1) !== e) begin n_fail++; $display("FAIL restart_wrap_ps got %b want %0d", ps1, e); end
  endtask

  task automatic test_pol();
    int hi0, hi1, e;
    hi0 = 0; hi1 = 0;
    en = 1'b0; pol = 4'b0001; cfg = '0;
    repeat (2) @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(256); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL pol_idle got %b want %0d", out1[0], e); end
    en = 1'b1;
    repeat (256) begin
      @(negedge clk);
      hi0 += int'(out1[0]);
      hi1 += int'(out1[1]);
    end
    e = exp_q.pop_front(); n_checks++;
    if (hi0 !== e) begin n_fail++; $display("FAIL pol_high_ch0 got %0d want %0d", hi0, e); end
    e = exp_q.pop_front(); n_checks++;
    if (hi1 !== e) begin n_fail++; $display("FAIL pol_high_ch1 got %0d want %0d", hi1, e); end
    en = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL pol_disabled got %b want %0d", out1[0], e); end
    en = 1'b1;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL pol_reenabled got %b want %0d", out1[0], e); end
    #1 nrst = 1'b0;
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (32'(out1[0]) !== e) begin n_fail++; $display("FAIL pol_in_reset got %b want %0d", out1[0], e); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_duty_div1();
    test_prescale();
    test_shadow();
    test_disable();
    test_pol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
